// File: rtl/dm_pkg.sv
// Shared encodings, exception codes and FSM state type for the MEM-stage data-memory controller.
package dm_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;

    localparam logic [1:0] SD_NONE = 2'd0;
    localparam logic [1:0] SD_SB   = 2'd1;
    localparam logic [1:0] SD_SH   = 2'd2;
    localparam logic [1:0] SD_SW   = 2'd3;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] TIMER_SIZE      = 32'd12;
    localparam logic [31:0] TIMER_COUNT_OFS = 32'd8;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && ((addr - base) < TIMER_SIZE);
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: write enables and replicated store data, plus extended load data.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wshift,
    output logic [31:0] rdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = 8'(rword >> {addr_lo, 3'b000});
    assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be     = '0;
        wshift = '0;
        case (store)
            SD_SB: begin
                be     = 4'b0001 << addr_lo;
                wshift = {4{wdata[7:0]}};
            end
            SD_SH: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wshift = {2{wdata[15:0]}};
            end
            SD_SW: begin
                be     = '1;
                wshift = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (load)
            LD_LB:   rdata = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU:  rdata = {24'd0, sel_byte};
            LD_LH:   rdata = {{16{sel_half[15]}}, sel_half};
            LD_LHU:  rdata = {16'd0, sel_half};
            LD_LW:   rdata = rword;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Multi-cycle data-memory controller: address-exception decode, wait states, zero-fill after reset.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] TIMER0_BASE = 32'h7f00,
    parameter logic [31:0] TIMER1_BASE = 32'h7f10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_load,
    input  logic [1:0]  req_store,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_exc,
    output logic [31:0] resp_pc,
    output logic        resp_timer,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    state_t        state;
    logic [AW-1:0] cnt;
    logic [3:0]    wcnt;
    logic [AW-1:0] a_idx;
    logic [1:0]    a_lo;
    logic [2:0]    a_load;
    logic [1:0]    a_store;
    logic [31:0]   a_wdata;
    logic [31:0]   a_pc;

    logic        has_ld, has_st, in_tmr, is_count, in_dm;
    logic        ld_fault, st_fault, dec_timer, dec_dm;
    logic [4:0]  dec_exc;
    logic        commit;
    logic [31:0] rword, lane_wdata, lane_rdata;
    logic [3:0]  lane_be;

    always_comb begin
        has_ld   = req_load != LD_NONE;
        has_st   = req_store != SD_NONE;
        in_tmr   = in_window(req_addr, TIMER0_BASE) | in_window(req_addr, TIMER1_BASE);
        is_count = (req_addr == TIMER0_BASE + TIMER_COUNT_OFS)
                 | (req_addr == TIMER1_BASE + TIMER_COUNT_OFS);
        in_dm    = (req_addr >> (AW + 2)) == '0;
        ld_fault = has_ld && (((req_load == LD_LW) && (req_addr[1:0] != 2'b00))
                           || (((req_load == LD_LH) || (req_load == LD_LHU)) && req_addr[0])
                           || ((req_load != LD_LW) && in_tmr)
                           || (!in_dm && !in_tmr));
        st_fault = (has_st && (((req_store == SD_SW) && (req_addr[1:0] != 2'b00))
                            || ((req_store == SD_SH) && req_addr[0])
                            || ((req_store != SD_SW) && in_tmr)
                            || ((req_store == SD_SW) && is_count)
                            || (!in_dm && !in_tmr)))
                 || (has_ld && has_st);
        dec_exc   = ld_fault ? EXC_ADEL : (st_fault ? EXC_ADES : EXC_NONE);
        // Timer windows take precedence over DM should the two ever overlap.
        dec_timer = !ld_fault && !st_fault && in_tmr && (has_ld || has_st);
        dec_dm    = !ld_fault && !st_fault && !in_tmr && (has_ld || has_st);
    end

    // wcnt runs 0..WAIT_CYCLES, so the access lands WAIT_CYCLES+1 edges after accept.
    assign commit = (state == S_WAIT) && (wcnt == 4'(WAIT_CYCLES));
    assign rword  = mem[a_idx];

    dm_lane u_lane (
        .addr_lo (a_lo),
        .load    (a_load),
        .store   (a_store),
        .wdata   (a_wdata),
        .rword   (rword),
        .be      (lane_be),
        .wshift  (lane_wdata),
        .rdata   (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[cnt] <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_be[i]) mem[a_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            cnt        <= '0;
            wcnt       <= '0;
            a_idx      <= '0;
            a_lo       <= '0;
            a_load     <= LD_NONE;
            a_store    <= SD_NONE;
            a_wdata    <= '0;
            a_pc       <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_exc   <= EXC_NONE;
            resp_pc    <= '0;
            resp_timer <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        a_idx     <= req_addr[AW+1:2];
                        a_lo      <= req_addr[1:0];
                        a_load    <= req_load;
                        a_store   <= req_store;
                        a_wdata   <= req_wdata;
                        a_pc      <= req_pc;
                        if (dec_dm) begin
                            wcnt  <= '0;
                            state <= S_WAIT;
                        end else begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_exc   <= dec_exc;
                            resp_pc    <= req_pc;
                            resp_timer <= dec_timer;
                        end
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= (a_load != LD_NONE) ? lane_rdata : '0;
                        resp_exc   <= EXC_NONE;
                        resp_pc    <= a_pc;
                        resp_timer <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: byte-addressed reference memory and cycle-accurate response queue.
module tb_dm_ctrl;

    localparam int          DEPTH = 32;
    localparam int          W     = 3;
    localparam logic [31:0] T0    = 32'h7f00;
    localparam logic [31:0] T1    = 32'h7f10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_load = '0;
    logic [1:0]  req_store = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_exc;
    logic [31:0] resp_pc;
    logic        resp_timer;
    logic        init_done;

    always #5 clk = ~clk;

    dm_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W),
        .TIMER0_BASE (T0),
        .TIMER1_BASE (T1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_exc   (resp_exc),
        .resp_pc    (resp_pc),
        .resp_timer (resp_timer),
        .init_done  (init_done)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        timer;
    } resp_t;

    resp_t       q[$];
    resp_t       last;
    logic [7:0]  mb [4*DEPTH];
    int          cyc = 0;
    int          exp_ready_from = 0;
    int          init_at = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;
    logic        exp_v;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the queued expectations.
    always @(negedge clk) begin
        if (reset && q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
        exp_v = reset && q.size() > 0 && q[0].cyc == cyc;
        if (exp_v) last = q.pop_front();
        chk("resp_valid", resp_valid, exp_v);
        chk("req_ready", req_ready, reset && cyc >= exp_ready_from);
        chk("init_done", init_done, reset && cyc >= init_at);
        chk("resp_data", resp_data, last.data);
        chk("resp_exc", resp_exc, last.exc);
        chk("resp_pc", resp_pc, last.pc);
        chk("resp_timer", resp_timer, last.timer);
    end

    function automatic resp_t model(input logic [31:0] a, input logic [2:0] ld, input logic [1:0] st,
                                    input logic [31:0] wd, input logic [31:0] pc, input int t);
        resp_t r;
        bit tmr, dm, lf, sf, legal;
        int nb;
        logic [31:0] val;
        tmr = (a >= T0 && a < T0 + 12) || (a >= T1 && a < T1 + 12);
        dm  = a < 4 * DEPTH;
        lf  = ld != 0 && ((ld == 5 && a % 4 != 0) || ((ld == 3 || ld == 4) && a % 2 != 0)
                          || (ld != 5 && tmr) || (!dm && !tmr));
        sf  = (st != 0 && ((st == 3 && a % 4 != 0) || (st == 2 && a % 2 != 0) || (st != 3 && tmr)
                           || (st == 3 && (a == T0 + 8 || a == T1 + 8)) || (!dm && !tmr)))
              || (ld != 0 && st != 0);
        r.exc   = lf ? 5'd4 : (sf ? 5'd5 : 5'd0);
        legal   = !lf && !sf && (ld != 0 || st != 0);
        r.timer = legal && tmr;
        r.pc    = pc;
        r.data  = '0;
        r.cyc   = (legal && !tmr) ? t + W + 1 : t;
        if (legal && !tmr && ld != 0) begin
            nb  = (ld <= 2) ? 1 : (ld <= 4 ? 2 : 4);
            val = '0;
            for (int i = 0; i < nb; i++) val = val | (32'(mb[a + i]) << (8 * i));
            if ((ld == 1 || ld == 3) && val[8*nb-1]) val = val | (32'hffffffff << (8 * nb));
            r.data = val;
        end
        if (legal && !tmr && st != 0) begin
            nb = (st == 1) ? 1 : (st == 2 ? 2 : 4);
            for (int i = 0; i < nb; i++) mb[a + i] = 8'(wd >> (8 * i));
        end
        return r;
    endfunction

    task automatic do_reset();
        int unsigned g;
        reset = 1'b0;
        q.delete();
        last = '{0, '0, '0, '0, 1'b0};
        foreach (mb[i]) mb[i] = '0;
        g = 0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        init_at = cyc + DEPTH;
        exp_ready_from = cyc + DEPTH;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [2:0] ld, input logic [1:0] st,
                          input logic [31:0] wd);
        int g;
        resp_t e;
        req_addr  = a;
        req_load  = ld;
        req_store = st;
        req_wdata = wd;
        req_pc    = pc_ctr;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout at cycle %0d: req_ready=%b, required 1", cyc, req_ready);
            req_valid = 1'b0;
            return;
        end
        e = model(a, ld, st, wd, pc_ctr, cyc + 1);
        q.push_back(e);
        exp_ready_from = e.cyc + 1;
        pc_ctr = pc_ctr + 4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_load  = 3'($urandom_range(0, 5));
        req_store = 2'($urandom_range(0, 3));
        req_wdata = $urandom;
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
    endtask

    task automatic expect_lit(input string name, input logic [31:0] d, input logic [4:0] x);
        drain();
        chk({name, "_data"}, resp_data, d);
        chk({name, "_exc"}, resp_exc, x);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  ld;
        logic [1:0]  st;
        int unsigned r;

        do_reset();
        for (int i = 0; i < DEPTH; i++) do_req(32'(4 * i), 3'd5, 2'd0, '0);
        expect_lit("zero_fill_last", 32'h0, 5'd0);

        do_req(32'h10, 3'd0, 2'd3, 32'h12345678);
        do_req(32'h13, 3'd1, 2'd0, '0); expect_lit("lb_13", 32'h00000012, 5'd0);
        do_req(32'h13, 3'd2, 2'd0, '0); expect_lit("lbu_13", 32'h00000012, 5'd0);
        do_req(32'h12, 3'd3, 2'd0, '0); expect_lit("lh_12", 32'h00001234, 5'd0);
        do_req(32'h12, 3'd4, 2'd0, '0); expect_lit("lhu_12", 32'h00001234, 5'd0);
        do_req(32'h10, 3'd5, 2'd0, '0); expect_lit("lw_10", 32'h12345678, 5'd0);

        do_req(32'h20, 3'd0, 2'd3, 32'h8000ff80);
        do_req(32'h21, 3'd0, 2'd1, 32'h000000aa);
        do_req(32'h21, 3'd1, 2'd0, '0); expect_lit("lb_21", 32'hffffffaa, 5'd0);
        do_req(32'h20, 3'd3, 2'd0, '0); expect_lit("lh_20", 32'hffffaa80, 5'd0);
        do_req(32'h20, 3'd5, 2'd0, '0); expect_lit("lw_20", 32'h8000aa80, 5'd0);

        do_req(32'h2,     3'd5, 2'd0, '0);           expect_lit("exc_lw_2", 32'h0, 5'd4);
        do_req(32'h7f00,  3'd3, 2'd0, '0);           expect_lit("exc_lh_t0", 32'h0, 5'd4);
        do_req(32'h7f00,  3'd1, 2'd0, '0);           expect_lit("exc_lb_t0", 32'h0, 5'd4);
        do_req(32'h7f08,  3'd0, 2'd3, 32'hffffffff); expect_lit("exc_sw_cnt", 32'h0, 5'd5);
        do_req(32'h7f10,  3'd0, 2'd2, 32'hffffffff); expect_lit("exc_sh_t1", 32'h0, 5'd5);
        do_req(32'h10,    3'd5, 2'd3, 32'hffffffff); expect_lit("exc_ld_st", 32'h0, 5'd5);
        do_req(32'h10000, 3'd5, 2'd0, '0);           expect_lit("exc_lw_far", 32'h0, 5'd4);
        do_req(32'h10, 3'd5, 2'd0, '0); expect_lit("lw_10_kept", 32'h12345678, 5'd0);
        do_req(32'h20, 3'd5, 2'd0, '0); expect_lit("lw_20_kept", 32'h8000aa80, 5'd0);
        do_req(32'h7f08, 3'd5, 2'd0, '0);            expect_lit("timer_lw", 32'h0, 5'd0);
        do_req(32'h7f14, 3'd0, 2'd3, 32'h5a5a5a5a);  expect_lit("timer_sw", 32'h0, 5'd0);
        do_req(32'h30, 3'd0, 2'd0, '0);              expect_lit("null_req", 32'h0, 5'd0);

        do_req(32'h40, 3'd0, 2'd3, 32'hdeadbeef);
        @(negedge clk);
        #1;
        do_reset();
        do_req(32'h40, 3'd5, 2'd0, '0); expect_lit("lw_40_after_reset", 32'h0, 5'd0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            ld = '0;
            st = '0;
            if (r < 45) ld = 3'($urandom_range(1, 5));
            else if (r < 85) st = 2'($urandom_range(1, 3));
            else if (r < 90) begin
                ld = 3'($urandom_range(1, 5));
                st = 2'($urandom_range(1, 3));
            end
            r = $urandom_range(0, 99);
            if (r < 75) a = 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (r < 90) a = ($urandom_range(0, 1) ? T0 : T1) + 32'($urandom_range(0, 11));
            else a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_req(a, ld, st, $urandom);
        end
        drain();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: simulation exceeded its time limit", cyc);
        $fatal(1, "watchdog");
    end

endmodule
